demux_1ne4_regjistruar: RTL
===========================

Name: demux_1ne4_regjistruar

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshake; the distribution counterpart of the CPU's 2:1 selection muxes.
- Routes one WIDTH-bit word per cycle to the output channel given by the select captured with it, for example to route write-back results to one of several destinations.
- Each output channel has a one-entry holding slot. A stalled channel blocks only words addressed to it.

Parameters:
- WIDTH, 16: data word width.
- N, 4: number of output channels, 2 to 2**SW.
- SW, 2: select width.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Hyrja  in  WIDTH  input data word.
- S  in  SW  destination channel select, sampled with Hyrja.
- HyrjaValid  in  1  upstream word valid.
- HyrjaGati  out  1  upstream ready (combinational).
- Dalja  out  N*WIDTH  packed channel data; channel i is at bits [i*WIDTH +: WIDTH].
- DaljaValid  out  N  per-channel slot full.
- DaljaGati  in  N  per-channel downstream ready.
- Gabim  out  1  one-cycle pulse: a word with an out-of-range select was discarded.
- NumeruesiPranimeve  out  16  count of accepted words.

Behaviour:
- Reset (synchronous, active-high) clears the following on the next edge: all slot data to 0, DaljaValid = 0, Gabim = 0, NumeruesiPranimeve = 0.
  - Reset overrides any accept or drain in the same cycle.
  - Words pending in slots are lost.
- Definitions:
  - drain[i] = DaljaValid[i] & DaljaGati[i].
  - accept = HyrjaValid & HyrjaGati.
- HyrjaGati:
  - If S < N: HyrjaGati = !DaljaValid[S] | DaljaGati[S].
  - If S >= N: HyrjaGati = 1.
  - It is a pure function of S, DaljaValid and DaljaGati; it never depends on HyrjaValid.
- Upstream rule: while HyrjaValid = 1 and no accept has occurred, Hyrja and S must not change.
- Accept with S = k < N:
  - Slot k data <= Hyrja and DaljaValid[k] <= 1 on the same edge.
  - Latency: exactly 1 cycle from the accept edge to DaljaValid.
  - No combinational path from Hyrja to Dalja.
- Drain of slot i with no load on the same edge: DaljaValid[i] <= 0. Slot data holds its last value, not cleared.
- Simultaneous drain and load of the same slot: DaljaValid stays 1 and data is replaced. This gives full throughput of one word per cycle per channel.
- Channels are independent.
  - Any subset may drain in one cycle.
  - At most one slot loads per cycle.
- Accept with S >= N (only reachable when N < 2**SW):
  - The word is discarded and no slot changes.
  - Gabim = 1 for exactly the cycle after the accept, else 0.
- NumeruesiPranimeve increments by 1 on every accept, including discarded ones. It wraps from 0xFFFF to 0x0000.
- Dalja[i] and DaljaValid[i] come straight from slot registers; no output logic after the flops.
- No state machine beyond the per-slot full flags. Slot state is EMPTY or FULL, with:
  - EMPTY to FULL on load.
  - FULL to EMPTY on drain without load.
  - FULL to FULL on drain with load, or on stall.

Decomposition:
- Shared package cpu_paketa holds:
  - the default WIDTH constant (16);
  - the channel-select typedef (logic [SW-1:0]);
  - the counter width constant (16).
- One natural sub-module, slot_dalje: a one-entry holding register.
  - Inputs: Clock, Reset, ngarko, data, gati.
  - Outputs: data, valid.
  - Instantiated N times via generate.
- The top level holds select decode, HyrjaGati, Gabim and the counter.

Test Plan:
- Reset, then idle → DaljaValid = 0000, Gabim = 0, NumeruesiPranimeve = 0, HyrjaGati = 1 for every S.
- Words 0x1234 (S=0), 0xABCD (S=2), 0x00FF (S=3) on three consecutive cycles, DaljaGati = 1111 → each word appears on its channel exactly 1 cycle after its accept, with DaljaValid one-hot per word; counter reaches 3.
- DaljaGati[1] = 0, then send 0xBEEF (S=1) followed by 0xCAFE (S=1) → the first is held; HyrjaGati = 0 while S=1; meanwhile a word with S=0 is accepted; raising DaljaGati[1] lets 0xCAFE load on the same edge that 0xBEEF drains.
- Continuous stream to S=2 with DaljaGati[2] = 1 for 20 cycles → 20 accepts, DaljaValid[2] stays 1, data matches input delayed by 1.
- Build with N=3, SW=2, send a word with S=3 → accepted, no DaljaValid change, Gabim pulses for 1 cycle, counter increments.
- Reset asserted while slots 0 and 2 are full and an accept is in flight → next cycle all DaljaValid = 0 and counter = 0; preload the counter to 0xFFFF and accept once → counter = 0x0000.

Source files
------------

// File: rtl/cpu_paketa.sv
// Shared constants and types for the CPU datapath blocks.
// Holds the default word width, channel-select type, counter width and slot states.
package cpu_paketa;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned SW_DEF    = 2;
  localparam int unsigned CNT_W     = 16;

  typedef logic [SW_DEF-1:0] zgjedhje_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } gjendje_slot_t;

endpackage

// File: rtl/slot_dalje.sv
// One-entry output holding slot: loads on i_ngarko, empties when drained without a load.
// Data is kept after a drain; only the full flag clears.
module slot_dalje
  import cpu_paketa::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_ngarko,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_gati,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  gjendje_slot_t    r_gjendje;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_gjendje <= SLOT_EMPTY;
      r_data    <= '0;
    end else if (i_ngarko) begin
      // a load wins over a same-edge drain, giving one word per cycle
      r_gjendje <= SLOT_FULL;
      r_data    <= i_data;
    end else if (r_gjendje == SLOT_FULL && i_gati) begin
      r_gjendje <= SLOT_EMPTY;
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_gjendje == SLOT_FULL);

endmodule

// File: rtl/demux_1ne4_regjistruar.sv
// Registered 1-to-N demultiplexer with valid/ready handshake and per-channel slots.
// Out-of-range selects are accepted, discarded and flagged on Gabim for one cycle.
module demux_1ne4_regjistruar
  import cpu_paketa::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = 4,
  parameter int unsigned SW    = SW_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Hyrja,
  input  logic [SW-1:0]      S,
  input  logic               HyrjaValid,
  output logic               HyrjaGati,
  output logic [N*WIDTH-1:0] Dalja,
  output logic [N-1:0]       DaljaValid,
  input  logic [N-1:0]       DaljaGati,
  output logic               Gabim,
  output logic [CNT_W-1:0]   NumeruesiPranimeve
);

  logic             w_pranim;
  logic             w_jashte;
  logic [N-1:0]     w_ngarko;
  logic [CNT_W-1:0] r_numeruesi;
  logic             r_gabim;

  // Selects that match no channel leave the ready default of 1.
  always_comb begin
    HyrjaGati = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      if (S == SW'(i)) HyrjaGati = !DaljaValid[i] | DaljaGati[i];
    end
  end

  assign w_pranim = HyrjaValid & HyrjaGati;

  always_comb begin
    w_ngarko = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_ngarko[i] = w_pranim && (S == SW'(i));
    end
  end

  generate
    if (N < (2 ** SW)) begin : g_jashte
      assign w_jashte = (32'(S) >= N);
    end else begin : g_plote
      assign w_jashte = 1'b0;
    end
  endgenerate

  generate
    for (genvar g = 0; g < N; g++) begin : g_slot
      slot_dalje #(
        .WIDTH(WIDTH)
      ) u_slot (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_ngarko(w_ngarko[g]),
        .i_data  (Hyrja),
        .i_gati  (DaljaGati[g]),
        .o_data  (Dalja[g*WIDTH +: WIDTH]),
        .o_valid (DaljaValid[g])
      );
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_gabim     <= 1'b0;
      r_numeruesi <= '0;
    end else begin
      r_gabim <= w_pranim & w_jashte;
      if (w_pranim) r_numeruesi <= r_numeruesi + CNT_W'(1);
    end
  end

  assign Gabim              = r_gabim;
  assign NumeruesiPranimeve = r_numeruesi;

endmodule
